// File: rtl/prog_pkg.sv
// Shared types and constants for the framed program loader.
package prog_pkg;

  // Frame parser / drain states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AH    = 3'd1,
    ST_AL    = 3'd2,
    ST_LEN   = 3'd3,
    ST_DH    = 3'd4,
    ST_DL    = 3'd5,
    ST_CSUM  = 3'd6,
    ST_DRAIN = 3'd7
  } state_t;

  // Frame result codes reported on ack_code
  localparam logic [1:0] ACK_OK   = 2'd0;
  localparam logic [1:0] ACK_CSUM = 2'd1;
  localparam logic [1:0] ACK_LEN  = 2'd2;
  localparam logic [1:0] ACK_OVR  = 2'd3;

  localparam logic [7:0]  SYNC_DEFAULT      = 8'h55;
  localparam int unsigned ADDR_W_DEFAULT    = 12;
  localparam int unsigned MAX_WORDS_DEFAULT = 32;
  localparam int unsigned TIMEOUT_DEFAULT   = 50000;
  localparam int unsigned WORD_W            = 16;

endpackage

// File: rtl/prog_word_buf.sv
// Payload buffer: simple dual-port RAM, one write port, one registered read port.
module prog_word_buf
  import prog_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_WORDS_DEFAULT,
  parameter int unsigned WIDTH = WORD_W,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_frame_decoder.sv
// Framed loader front end: parses SYNC/ADDR/LEN/DATA/CSUM frames from the UART,
// buffers the payload and only releases ROM word writes once the checksum is good.
// Optional inter-byte timeout: define PROG_TIMEOUT_EN.
module prog_frame_decoder
  import prog_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned MAX_WORDS   = MAX_WORDS_DEFAULT,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              busy,
  output logic              ack_valid,
  output logic [1:0]        ack_code
);

  localparam int unsigned IDX_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned BUF_AW = $clog2(MAX_WORDS);

  state_t state, state_nxt;

  logic [7:0]        hold, hold_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [IDX_W-1:0]  len, len_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [7:0]        sum, sum_nxt;
  logic              ovr, ovr_nxt;

  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [15:0]       wr_data_nxt;
  logic              wr_valid_nxt;
  logic              busy_nxt;
  logic              ack_valid_nxt;
  logic [1:0]        ack_code_nxt;

  logic        buf_we_c;
  logic [15:0] rd_data;
  logic [7:0]  sum_add_c;
  logic        len_bad_c;
  logic        last_word_c;
  logic        drain_step_c;
  logic        drain_done_c;
  logic        tmo_hit_c;

  assign sum_add_c    = sum + rx_data;
  assign len_bad_c    = (rx_data == 8'd0) || (32'(rx_data) > MAX_WORDS);
  assign last_word_c  = (IDX_W'(idx + IDX_W'(1)) == len);
  assign drain_step_c = !wr_valid || wr_ready;
  assign drain_done_c = drain_step_c && (idx == len);

`ifdef PROG_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             parse_c;

  assign parse_c = (state inside {ST_AH, ST_AL, ST_LEN, ST_DH, ST_DL, ST_CSUM});

  // Inter-byte idle counter, restarted by every byte while a frame is being parsed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (!parse_c || rx_valid) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit_c = parse_c && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC == 0);
  assign tmo_hit_c  = 1'b0;
`endif

  // Payload buffer; read address is the next index so rd_data tracks buf[idx] in DRAIN
  prog_word_buf #(
    .DEPTH (MAX_WORDS),
    .WIDTH (WORD_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we_c),
    .waddr (BUF_AW'(idx)),
    .wdata ({hold, rx_data}),
    .raddr (BUF_AW'(idx_nxt)),
    .rdata (rd_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; parse states advance only on rx_valid
  always_comb begin
    state_nxt = state;
    if (tmo_hit_c) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (rx_valid && rx_data == SYNC_BYTE) state_nxt = ST_AH;
        ST_AH:    if (rx_valid) state_nxt = ST_AL;
        ST_AL:    if (rx_valid) state_nxt = ST_LEN;
        ST_LEN:   if (rx_valid) state_nxt = len_bad_c ? ST_IDLE : ST_DH;
        ST_DH:    if (rx_valid) state_nxt = ST_DL;
        ST_DL:    if (rx_valid) state_nxt = last_word_c ? ST_CSUM : ST_DH;
        ST_CSUM:  if (rx_valid) state_nxt = (sum_add_c == 8'h00) ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: if (drain_done_c) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    hold_nxt      = hold;
    base_nxt      = base;
    len_nxt       = len;
    idx_nxt       = idx;
    sum_nxt       = sum;
    ovr_nxt       = ovr;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    wr_valid_nxt  = wr_valid;
    busy_nxt      = busy;
    ack_valid_nxt = 1'b0;
    ack_code_nxt  = ack_code;
    buf_we_c      = 1'b0;

    if (tmo_hit_c) begin
      ack_valid_nxt = 1'b1;
      ack_code_nxt  = ACK_OVR;
      busy_nxt      = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            sum_nxt  = 8'h00;
            idx_nxt  = '0;
            ovr_nxt  = 1'b0;
            busy_nxt = 1'b1;
          end
        end
        ST_AH, ST_DH: begin
          if (rx_valid) begin
            hold_nxt = rx_data;
            sum_nxt  = sum_add_c;
          end
        end
        ST_AL: begin
          if (rx_valid) begin
            base_nxt = ADDR_W'({hold, rx_data});
            sum_nxt  = sum_add_c;
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            sum_nxt = sum_add_c;
            if (len_bad_c) begin
              ack_valid_nxt = 1'b1;
              ack_code_nxt  = ACK_LEN;
              busy_nxt      = 1'b0;
            end else begin
              len_nxt = IDX_W'(rx_data);
              idx_nxt = '0;
            end
          end
        end
        ST_DL: begin
          if (rx_valid) begin
            buf_we_c = 1'b1;
            idx_nxt  = idx + IDX_W'(1);
            sum_nxt  = sum_add_c;
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            sum_nxt = sum_add_c;
            if (sum_add_c == 8'h00) begin
              idx_nxt = '0;
            end else begin
              ack_valid_nxt = 1'b1;
              ack_code_nxt  = ACK_CSUM;
              busy_nxt      = 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (rx_valid) ovr_nxt = 1'b1;
          if (drain_step_c) begin
            if (idx != len) begin
              wr_valid_nxt = 1'b1;
              wr_data_nxt  = rd_data;
              wr_addr_nxt  = base + ADDR_W'(idx);
              idx_nxt      = idx + IDX_W'(1);
            end else begin
              wr_valid_nxt  = 1'b0;
              ack_valid_nxt = 1'b1;
              ack_code_nxt  = (ovr || rx_valid) ? ACK_OVR : ACK_OK;
              busy_nxt      = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      base      <= '0;
      len       <= '0;
      idx       <= '0;
      sum       <= '0;
      ovr       <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_valid  <= 1'b0;
      busy      <= 1'b0;
      ack_valid <= 1'b0;
      ack_code  <= '0;
    end else begin
      hold      <= hold_nxt;
      base      <= base_nxt;
      len       <= len_nxt;
      idx       <= idx_nxt;
      sum       <= sum_nxt;
      ovr       <= ovr_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      wr_valid  <= wr_valid_nxt;
      busy      <= busy_nxt;
      ack_valid <= ack_valid_nxt;
      ack_code  <= ack_code_nxt;
    end
  end

endmodule

// File: tb/tb_prog_frame_decoder.sv
// Directed bench for prog_frame_decoder (optional timeout case under PROG_TIMEOUT_EN).
module tb_prog_frame_decoder;

  localparam int unsigned ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              busy;
  logic              ack_valid;
  logic [1:0]        ack_code;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_frame_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .ack_valid (ack_valid),
    .ack_code  (ack_code)
  );

  // Observed handshakes, acks and stall stability, sampled mid-cycle
  logic [ADDR_W-1:0] got_addr [$];
  logic [15:0]       got_data [$];
  int                ack_cnt = 0, wv_cycles = 0, both_cnt = 0, stall_err = 0, stall_cycles = 0;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [15:0]       prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!wr_valid || wr_addr !== prev_addr || wr_data !== prev_data)) stall_err++;
      if (wr_valid) wv_cycles++;
      if (wr_valid && ack_valid) both_cnt++;
      if (ack_valid) ack_cnt++;
      if (wr_valid && wr_ready) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
      end
      if (wr_valid && !wr_ready) stall_cycles++;
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  int s_ack, s_wv, s_hs, s_stall;
  logic [7:0]        fb [$];
  logic [ADDR_W-1:0] ea [$];
  logic [15:0]       ed [$];
  bit                seen;
  logic [1:0]        code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    s_ack   = ack_cnt;
    s_wv    = wv_cycles;
    s_hs    = got_addr.size();
    s_stall = stall_cycles;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // SYNC, body bytes, then the two's-complement checksum plus adj
  task automatic send_frame(input logic [7:0] body [$], input logic [7:0] adj);
    logic [7:0] s;
    s = 8'h00;
    send_byte(8'h55);
    foreach (body[i]) begin
      send_byte(body[i]);
      s = s + body[i];
    end
    send_byte(8'(8'h00 - s) + adj);
  endtask

  task automatic run_drain(input bit bp, output bit ok, output logic [1:0] c);
    ok = 1'b0;
    c  = 2'd0;
    for (int k = 0; k < 300 && !ok; k++) begin
      if (bp) wr_ready = (k % 3 == 2);
      @(posedge clk); #1;
      if (ack_valid) begin
        ok = 1'b1;
        c  = ack_code;
      end
    end
    wr_ready = 1'b1;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(got_addr.size() - s_hs), 32'(ea.size()));
    foreach (ea[i]) begin
      if (s_hs + i < got_addr.size()) begin
        check({tag, "_addr"}, 32'(got_addr[s_hs + i]), 32'(ea[i]));
        check({tag, "_data"}, 32'(got_data[s_hs + i]), 32'(ed[i]));
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack_valid", 32'(ack_valid), 32'd0);
    check("rst_ack_code", 32'(ack_code), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Noise in IDLE is ignored
    send_byte(8'hA7);
    send_byte(8'h00);
    check("idle_noise_busy", 32'(busy), 32'd0);

    // Good frame: two words at 0x100, first write two cycles after the CSUM byte
    mark();
    fb = '{8'h01, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_frame(fb, 8'h00);
    check("t1_lat_early", 32'(wr_valid), 32'd0);
    check("t1_busy_drain", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("t1_lat_first", 32'(wr_valid), 32'd1);
    check("t1_first_addr", 32'(wr_addr), 32'h100);
    check("t1_first_data", 32'(wr_data), 32'h1234);
    run_drain(1'b0, seen, code);
    check("t1_ack_seen", 32'(seen), 32'd1);
    check("t1_ack_code", 32'(code), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    ea = '{12'h100, 12'h101};
    ed = '{16'h1234, 16'hABCD};
    check_writes("t1");

    // Same frame with corrupted checksum
    mark();
    send_frame(fb, 8'h01);
    check("t2_ack_valid", 32'(ack_valid), 32'd1);
    check("t2_ack_code", 32'(ack_code), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("t2_no_wr", 32'(wv_cycles - s_wv), 32'd0);

    // LEN = 0
    send_byte(8'h55);
    send_byte(8'h01);
    check("t3_busy_in_frame", 32'(busy), 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t3_len0_ack", 32'(ack_valid), 32'd1);
    check("t3_len0_code", 32'(ack_code), 32'd2);
    check("t3_len0_busy", 32'(busy), 32'd0);

    // LEN = MAX_WORDS + 1
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h21);
    check("t3_len33_ack", 32'(ack_valid), 32'd1);
    check("t3_len33_code", 32'(ack_code), 32'd2);

    // Following good frame is accepted
    mark();
    fb = '{8'h00, 8'h20, 8'h01, 8'hBE, 8'hEF};
    send_frame(fb, 8'h00);
    run_drain(1'b0, seen, code);
    check("t3_good_seen", 32'(seen), 32'd1);
    check("t3_good_code", 32'(code), 32'd0);
    ea = '{12'h020};
    ed = '{16'hBEEF};
    check_writes("t3_good");

    // Backpressure: ready one cycle in three
    mark();
    fb = '{8'h02, 8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    send_frame(fb, 8'h00);
    run_drain(1'b1, seen, code);
    check("t4_seen", 32'(seen), 32'd1);
    check("t4_code", 32'(code), 32'd0);
    check("t4_stalled", 32'((stall_cycles - s_stall) > 0), 32'd1);
    check("t4_stable", 32'(stall_err), 32'd0);
    ea = '{12'h200, 12'h201, 12'h202};
    ed = '{16'h1111, 16'h2222, 16'h3333};
    check_writes("t4");

    // Address wrap past the top of the ROM
    mark();
    fb = '{8'h0F, 8'hFF, 8'h02, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
    send_frame(fb, 8'h00);
    run_drain(1'b0, seen, code);
    check("t5_seen", 32'(seen), 32'd1);
    check("t5_code", 32'(code), 32'd0);
    ea = '{12'hFFF, 12'h000};
    ed = '{16'hA5A5, 16'h5A5A};
    check_writes("t5");

    // Overrun: byte arrives while draining
    mark();
    fb = '{8'h03, 8'h00, 8'h02, 8'hC0, 8'h01, 8'hC0, 8'h02};
    send_frame(fb, 8'h00);
    send_byte(8'h55);
    run_drain(1'b0, seen, code);
    check("t6_seen", 32'(seen), 32'd1);
    check("t6_code", 32'(code), 32'd3);
    ea = '{12'h300, 12'h301};
    ed = '{16'hC001, 16'hC002};
    check_writes("t6");

    // Overrun flag does not leak into the next frame
    fb = '{8'h00, 8'h20, 8'h01, 8'hBE, 8'hEF};
    send_frame(fb, 8'h00);
    run_drain(1'b0, seen, code);
    check("t6_next_code", 32'(code), 32'd0);

    // Asynchronous reset mid-drain
    wr_ready = 1'b0;
    fb = '{8'h04, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(fb, 8'h00);
    @(posedge clk); #1;
    check("t7_pre_valid", 32'(wr_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_valid", 32'(wr_valid), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    mark();
    @(posedge clk); #1;
    rst      = 1'b0;
    wr_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t7_no_ack", 32'(ack_cnt - s_ack), 32'd0);
    check("t7_no_wr", 32'(got_addr.size() - s_hs), 32'd0);

`ifdef PROG_TIMEOUT_EN
    // Stall after ADDR_L until the inter-byte timeout fires
    begin
      int n;
      send_byte(8'h55);
      send_byte(8'h01);
      send_byte(8'h00);
      seen = 1'b0;
      n    = 0;
      for (int k = 0; k < 50100 && !seen; k++) begin
        @(posedge clk); #1;
        n++;
        if (ack_valid) begin
          seen = 1'b1;
          code = ack_code;
        end
      end
      check("tmo_seen", 32'(seen), 32'd1);
      check("tmo_code", 32'(code), 32'd3);
      check("tmo_not_early", 32'(n >= 49990), 32'd1);
      check("tmo_busy", 32'(busy), 32'd0);
    end
`endif

    // Clean recovery frame after reset
    mark();
    fb = '{8'h01, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_frame(fb, 8'h00);
    run_drain(1'b0, seen, code);
    check("t8_seen", 32'(seen), 32'd1);
    check("t8_code", 32'(code), 32'd0);
    ea = '{12'h100, 12'h101};
    ed = '{16'h1234, 16'hABCD};
    check_writes("t8");

    check("ack_wr_overlap", 32'(both_cnt), 32'd0);
    check("stall_stability", 32'(stall_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
